// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C target that oversamples scl/sda on clk and serves a simple register port.
// Optional macro SCCB_TARGET_AUTOINC_EN: reg_addr advances after every reg_wr_en / reg_rd_en.
module sccb_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wdata,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       xfer_done
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, RADDR, RADDR_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_d, sda_d;
    logic       scl_rise, scl_fall, start_c, stop_c;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte;
    logic [7:0] tx_sr;
    logic [3:0] bit_cnt;
    logic       drv;
    logic       rw;
    logic       addressed;
    logic       last_bit;
    logic       dev_match;
    logic       sda_oe;

    // Synchronisers come out of reset at the idle-bus level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain really is N stages.
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_c   = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c    = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte   = {rx_sr, sda_s};
    assign last_bit  = (bit_cnt == 4'd7);
    assign dev_match = (rx_byte[7:1] == DEV_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_n and no latch is inferred.
        state_n = state;
        if (start_c) begin
            state_n = DEV;
        end else if (stop_c) begin
            state_n = IDLE;
        end else begin
            case (state)
                DEV:       if (scl_rise && last_bit) state_n = dev_match ? DEV_ACK : IGNORE;
                DEV_ACK:   if (scl_fall && drv)      state_n = rw ? RDATA : RADDR;
                RADDR:     if (scl_rise && last_bit) state_n = RADDR_ACK;
                RADDR_ACK: if (scl_fall && drv)      state_n = WDATA;
                WDATA:     if (scl_rise && last_bit) state_n = WDATA_ACK;
                WDATA_ACK: if (scl_fall && drv)      state_n = WDATA;
                RDATA:     if (scl_fall && drv && bit_cnt == 4'd8) state_n = MACK;
                MACK:      if (scl_rise)             state_n = sda_s ? IGNORE : RDATA;
                default:   state_n = state;
            endcase
        end
    end

    // drv: in ACK states it marks the driven half of the ack bit; in RDATA it marks that bits are being driven.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            drv       <= 1'b0;
            rw        <= 1'b0;
            addressed <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            xfer_done <= 1'b0;
`ifdef SCCB_TARGET_AUTOINC_EN
            if (reg_wr_en || reg_rd_en) reg_addr <= reg_addr + 8'd1;
`endif
            if (reg_rd_en) tx_sr <= reg_rdata;

            if (start_c) begin
                bit_cnt <= '0;
                drv     <= 1'b0;
            end else if (stop_c) begin
                bit_cnt   <= '0;
                drv       <= 1'b0;
                xfer_done <= addressed;
                addressed <= 1'b0;
            end else begin
                case (state)
                    DEV, RADDR, WDATA: begin
                        if (scl_rise) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                            drv     <= 1'b0;
                            if (last_bit) begin
                                if (state == DEV && dev_match) begin
                                    addressed <= 1'b1;
                                    rw        <= rx_byte[0];
                                    reg_rd_en <= rx_byte[0];
                                end
                                if (state == RADDR) reg_addr <= rx_byte;
                                if (state == WDATA) begin
                                    reg_wdata <= rx_byte;
                                    reg_wr_en <= 1'b1;
                                end
                            end
                        end
                    end
                    DEV_ACK, RADDR_ACK, WDATA_ACK: begin
                        // A read keeps drv set so the first data bit follows the ack without a gap.
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            drv     <= !drv || (state == DEV_ACK && rw);
                        end
                    end
                    RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (!drv)                  drv   <= 1'b1;
                            else if (bit_cnt == 4'd8)  drv   <= 1'b0;
                            else                       tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    MACK: begin
                        if (scl_rise && !sda_s) begin
                            reg_rd_en <= 1'b1;
                            bit_cnt   <= '0;
                            drv       <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        sda_oe = 1'b0;
        busy   = (state != IDLE);
        case (state)
            DEV_ACK, RADDR_ACK, WDATA_ACK: sda_oe = drv;
            RDATA:                         sda_oe = drv & ~tx_sr[7];
            default:                       sda_oe = 1'b0;
        endcase
    end

    // Open drain: only ever pull low.
    assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bus-master driven bench with a register-map reference model for sccb_target.
`timescale 1ns/1ps
module tb_sccb_target;

    localparam int Q = 5;  // clk cycles per quarter scl period

`ifdef SCCB_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr_en, reg_rd_en, busy, xfer_done;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sccb_target dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .reg_addr  (reg_addr),
        .reg_wr_en (reg_wr_en),
        .reg_wdata (reg_wdata),
        .reg_rd_en (reg_rd_en),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    // Register file behind the port; reset loads a known pattern.
    logic [7:0] regs [256];
    assign reg_rdata = regs[reg_addr];
    always @(posedge clk) begin
        if (!rst) for (int i = 0; i < 256; i++) regs[i] <= 8'(i) ^ 8'h5A;
        else if (reg_wr_en) regs[reg_addr] <= reg_wdata;
    end

    // Monitor: records every strobe and protocol anomaly.
    wr_t        got_wr [$];
    logic [7:0] got_rd [$];
    int         got_xd = 0, both_cnt = 0, dut_low_cnt = 0, hi_chg = 0;
    logic       p_scl = 1'b1, p_sda = 1'b1, p_mlow = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (reg_wr_en) got_wr.push_back({reg_addr, reg_wdata});
            if (reg_rd_en) got_rd.push_back(reg_addr);
            if (reg_wr_en && reg_rd_en) both_cnt++;
            if (xfer_done) got_xd++;
            if (sda === 1'b0 && !m_low) dut_low_cnt++;
            if (scl && p_scl && (sda !== p_sda) && (m_low == p_mlow)) hi_chg++;
        end
        p_scl  = scl;
        p_sda  = sda;
        p_mlow = m_low;
    end

    // Reference model: register map, pointer and expected strobe streams.
    logic [7:0] m_regs [256];
    logic [7:0] m_ptr;
    wr_t        exp_wr [$];
    logic [7:0] exp_rd [$];
    int         exp_xd = 0;
    int         wr_i = 0, rd_i = 0;
    int         n_vec = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_regs[i] = 8'(i) ^ 8'h5A;
        m_ptr = 8'h00;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        m_low = 1'b0; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        m_low = 1'b1; wait_clk(Q);
        scl   = 1'b0;
    endtask

    task automatic m_stop();
        m_low = 1'b1; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        m_low = 1'b0; wait_clk(2 * Q);
    endtask

    task automatic m_bit(input logic b, output logic s);
        wait_clk(Q);
        m_low = ~b; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        s     = (sda === 1'b0) ? 1'b0 : 1'b1;
        wait_clk(Q);
        scl   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            d[i] = s;
        end
        m_bit(~ack, s);
    endtask

    task automatic verify(input string tag);
        wait_clk(4);
        check({tag, ":n_wr"}, got_wr.size(), exp_wr.size());
        for (int i = wr_i; i < exp_wr.size() && i < got_wr.size(); i++) begin
            check({tag, ":wr_addr"}, got_wr[i].a, exp_wr[i].a);
            check({tag, ":wr_data"}, got_wr[i].d, exp_wr[i].d);
        end
        check({tag, ":n_rd"}, got_rd.size(), exp_rd.size());
        for (int i = rd_i; i < exp_rd.size() && i < got_rd.size(); i++)
            check({tag, ":rd_addr"}, got_rd[i], exp_rd[i]);
        check({tag, ":xfer_done"}, got_xd, exp_xd);
        check({tag, ":reg_addr"}, reg_addr, m_ptr);
        check({tag, ":busy_idle"}, busy, 1'b0);
        wr_i = exp_wr.size();
        rd_i = exp_rd.size();
    endtask

    task automatic xact_write(input string tag, input logic [7:0] ra, input logic [7:0] d [$]);
        logic a;
        m_start();
        wait_clk(Q);
        check({tag, ":busy"}, busy, 1'b1);
        send_byte(8'h42, a); check({tag, ":dev_ack"}, a, 1'b1);
        send_byte(ra, a);    check({tag, ":raddr_ack"}, a, 1'b1);
        m_ptr = ra;
        foreach (d[i]) begin
            send_byte(d[i], a); check({tag, ":wdata_ack"}, a, 1'b1);
            exp_wr.push_back({m_ptr, d[i]});
            m_regs[m_ptr] = d[i];
            if (AUTOINC) m_ptr = m_ptr + 8'd1;
        end
        m_stop();
        exp_xd++;
        verify(tag);
    endtask

    task automatic xact_read(input string tag, input logic [7:0] ra, input int n);
        logic       a;
        logic [7:0] d;
        m_start();
        send_byte(8'h42, a); check({tag, ":dev_ack"}, a, 1'b1);
        send_byte(ra, a);    check({tag, ":raddr_ack"}, a, 1'b1);
        m_ptr = ra;
        m_start();
        send_byte(8'h43, a); check({tag, ":rdev_ack"}, a, 1'b1);
        for (int k = 0; k < n; k++) begin
            exp_rd.push_back(m_ptr);
            recv_byte(k < n - 1, d);
            check({tag, ":rdata"}, d, m_regs[m_ptr]);
            if (AUTOINC) m_ptr = m_ptr + 8'd1;
        end
        m_stop();
        exp_xd++;
        verify(tag);
    endtask

    task automatic xact_bad(input string tag, input logic [7:0] dev);
        logic a;
        int   low0;
        low0 = dut_low_cnt;
        m_start();
        send_byte(dev, a);            check({tag, ":dev_nack"}, a, 1'b0);
        send_byte(8'($urandom), a);   check({tag, ":b1_nack"}, a, 1'b0);
        send_byte(8'($urandom), a);   check({tag, ":b2_nack"}, a, 1'b0);
        m_stop();
        check({tag, ":sda_never_low"}, dut_low_cnt - low0, 0);
        verify(tag);
    endtask

    initial begin
        logic [7:0] d [$];
        logic       a, s;
        logic [6:0] dev7;

        model_reset();
        wait_clk(5);
        check("rst:sda", sda === 1'b1, 1'b1);
        check("rst:reg_addr", reg_addr, 8'h00);
        check("rst:strobes", {reg_wr_en, reg_rd_en, xfer_done, busy}, 4'b0000);
        check("rst:reg_wdata", reg_wdata, 8'h00);
        rst = 1'b1;
        wait_clk(5);

        d = '{8'h80};
        xact_write("t1", 8'h12, d);

        d = '{8'h7F};
        xact_write("t2w", 8'h0A, d);
        xact_read("t2r", 8'h0A, 1);

        xact_bad("t3", 8'h44);

        // STOP after four data bits: partial byte must be dropped
        m_start();
        send_byte(8'h42, a); check("t4:dev_ack", a, 1'b1);
        send_byte(8'h05, a); check("t4:raddr_ack", a, 1'b1);
        m_ptr = 8'h05;
        for (int i = 0; i < 4; i++) m_bit(1'b1, s);
        m_stop();
        exp_xd++;
        verify("t4");
        d = '{8'h3C};
        xact_write("t4n", 8'h06, d);

        d = '{8'h11, 8'h22};
        xact_write("t5", 8'hFF, d);
        xact_read("t5r", 8'hFF, 2);

        // Reset while the target is pulling sda low for a 0 read bit
        d = '{8'h00};
        xact_write("t6w", 8'h30, d);
        m_start();
        send_byte(8'h42, a); check("t6:dev_ack", a, 1'b1);
        send_byte(8'h30, a); check("t6:raddr_ack", a, 1'b1);
        m_start();
        send_byte(8'h43, a); check("t6:rdev_ack", a, 1'b1);
        exp_rd.push_back(8'h30);
        wait_clk(Q + 2);
        check("t6:drive_low", sda === 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check("t6:sda_released", sda === 1'b1, 1'b1);
        check("t6:outputs", {reg_wr_en, reg_rd_en, xfer_done, busy}, 4'b0000);
        check("t6:reg_addr", reg_addr, 8'h00);
        wait_clk(3);
        m_low = 1'b0;
        scl   = 1'b1;
        wait_clk(2);
        rst = 1'b1;
        model_reset();
        wait_clk(Q);
        d = '{8'hA5};
        xact_write("t6n", 8'h31, d);
        xact_read("t6r", 8'h31, 1);

        for (int it = 0; it < 15; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    d.delete();
                    for (int k = 0; k < $urandom_range(1, 3); k++) d.push_back(8'($urandom));
                    xact_write("rnd_w", 8'($urandom), d);
                end
                1: xact_read("rnd_r", 8'($urandom), $urandom_range(1, 3));
                default: begin
                    dev7 = 7'($urandom);
                    if (dev7 == 7'h21) dev7 = 7'h22;
                    xact_bad("rnd_bad", {dev7, 1'($urandom)});
                end
            endcase
        end

        check("end:wr_rd_overlap", both_cnt, 0);
        check("end:sda_change_scl_high", hi_chg, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
